pll_loop_ctrl: RTL and testbench
================================

PLL_LOOP_CTRL -- requirements
Module: pll_loop_ctrl

Interface
REQ-001 SHALL have parameter ERR_W, default 12, signed phase-error width.
REQ-002 SHALL have parameter TUNE_W, default 16, unsigned tuning-word width.
REQ-003 SHALL have parameter ACC_W, default 24, NCO accumulator width.
REQ-004 SHALL have parameters KP_SHIFT (default 1) and KI_SHIFT (default 4), the proportional and integral arithmetic right-shifts.
REQ-005 SHALL have parameters LOCK_TOL (default 2) and LOCK_CNT (default 8), the lock error band and the required consecutive in-band count.
REQ-006 SHALL have these ports:
- clk, in, 1, sampling/system clock.
- rstn, in, 1, reset: asynchronous, active-low.
- en, in, 1, loop enable.
- ref_clk, in, 1, asynchronous reference clock.
- fb_clk, in, 1, asynchronous feedback clock.
- phase_signal, in, 1, asynchronous PFD XOR output.
- tune_init, in, TUNE_W, nominal tuning word.
- gen_clk, out, 1, NCO clock output.
- tune_word, out, TUNE_W, current tuning word.
- phase_err, out, signed ERR_W, last measured error.
- err_valid, out, 1, one-cycle pulse when a new phase_err is presented.
- locked, out, 1, lock indicator.

Function
REQ-007 SHALL synchronize ref_clk, fb_clk and phase_signal with 2-flop synchronizers, and SHALL detect rising edges on synced ref/fb.
REQ-008 SHALL implement FSM states IDLE, WAIT_EDGE, MEASURE and UPDATE.
REQ-009 IDLE behaviour:
- integrator is held at 0, tune_word at tune_init, locked and the lock counter at 0.
- en=1 moves to WAIT_EDGE.
REQ-010 WAIT_EDGE behaviour:
- ref edge alone: sign +, count 0, go to MEASURE.
- fb edge alone: sign -, count 0, go to MEASURE.
- both edges in the same cycle: error 0, go directly to UPDATE.
REQ-011 MEASURE SHALL increment count by one every cycle.
REQ-012 MEASURE SHALL exit to UPDATE on the first of the following; repeated same-side edges are ignored:
- opposite edge, counted in that cycle.
- synced phase_signal falling.
- count reaching 2^(ERR_W-1)-1 (saturation).
REQ-013 UPDATE SHALL last one cycle and SHALL perform these actions:
- phase_err = sign*count.
- err_valid = 1.
- integ = saturate(integ + phase_err) at 2*ERR_W bits signed.
- tune_word = clamp(tune_init + (phase_err>>>KP_SHIFT) + (integ_new>>>KI_SHIFT), 0, 2^TUNE_W-1).
- Next state: WAIT_EDGE, or IDLE if en=0.
REQ-014 Positive phase_err (ref leads) SHALL increase tune_word.
REQ-015 NCO: when en=1, acc <= acc + tune_word mod 2^ACC_W every cycle; gen_clk SHALL be registered acc MSB; when en=0, acc and gen_clk hold.
REQ-016 en deasserted in any state SHALL force IDLE next cycle, discard the partial measurement and produce no err_valid.
REQ-017 Lock counter SHALL evaluate each UPDATE:
- |phase_err| <= LOCK_TOL: increment, saturating at LOCK_CNT.
- otherwise: clear to 0 and clear locked.
- locked = 1 from the UPDATE in which the counter reaches LOCK_CNT.

Reset
REQ-018 rstn low SHALL asynchronously set:
- FSM to IDLE.
- acc, integ, count and lock counter to 0.
- gen_clk, tune_word, phase_err, err_valid and locked to 0.
- synchronizer flops to 0.
REQ-019 After rstn release, tune_word SHALL take tune_init on the first clk edge.

Configuration
REQ-020 Macro PLL_LOCK_DET_EN defined SHALL compile in the lock counter and locked logic per REQ-017.
REQ-021 With PLL_LOCK_DET_EN undefined, locked SHALL be tied 0, no lock counter SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-022 Shared package pll_pkg SHALL hold:
- the FSM state enum typedef.
- default width constants.
- signed saturate and unsigned clamp functions.
REQ-023 Sub-module sync_2ff (2-flop synchronizer, async active-low reset) SHALL be instantiated three times.

Verification
REQ-024 The bench SHALL cover these scenarios (tune_init=0x1000 unless stated; defaults used; lock scenario requires PLL_LOCK_DET_EN):
- ref leads fb by 10 clk -> phase_err=+10, tune_word=0x1005, one err_valid pulse.
- After fresh IDLE, fb leads by 6 -> phase_err=-6, tune_word=0x0FFC.
- ref/fb edges in the same synced cycle -> phase_err=0, tune_word=0x1000.
- ref edges only, no fb, phase_signal high -> phase_err=+2047 after 2047 cycles, tune_word=0x147E.
- tune_init=0xFFF0, error +100 -> tune_word clamps to 0xFFFF.
- Lock: eight updates at phase_err=+1 -> locked=1 on the 8th; next at +5 -> locked=0.
- en dropped mid-MEASURE -> no err_valid, tune_word returns to tune_init, gen_clk frozen.

Source files
------------

// File: rtl/pll_pkg.sv
// -----------------------------------------------------------------------------
// pll_pkg
// Shared definitions for the PLL loop controller:
//   - pll_state_e     : loop-controller FSM state encoding
//   - *_DEF constants : default parameter values used by pll_loop_ctrl
//   - sat_signed      : saturate a signed value to a given two's-complement width
//   - clamp_unsigned  : clamp a signed value into [0, 2^width-1]
// Both helpers work on 64-bit signed intermediates; callers truncate the result
// to their own width afterwards.
// -----------------------------------------------------------------------------
package pll_pkg;

  localparam int ERR_W_DEF    = 12;
  localparam int TUNE_W_DEF   = 16;
  localparam int ACC_W_DEF    = 24;
  localparam int KP_SHIFT_DEF = 1;
  localparam int KI_SHIFT_DEF = 4;
  localparam int LOCK_TOL_DEF = 2;
  localparam int LOCK_CNT_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_EDGE = 2'd1,
    ST_MEASURE   = 2'd2,
    ST_UPDATE    = 2'd3
  } pll_state_e;

  // Saturate val to the signed range of a width-bit two's-complement number.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] val,
                                                    input int width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (val > max_v) begin
      return max_v;
    end else if (val < min_v) begin
      return min_v;
    end else begin
      return val;
    end
  endfunction

  // Clamp val into the unsigned range of a width-bit number.
  function automatic logic signed [63:0] clamp_unsigned(input logic signed [63:0] val,
                                                        input int width);
    logic signed [63:0] max_v;
    max_v = (64'sd1 <<< width) - 64'sd1;
    if (val < 64'sd0) begin
      return 64'sd0;
    end else if (val > max_v) begin
      return max_v;
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Ports:
//   clk  : destination clock
//   rstn : asynchronous active-low reset (both flops clear to 0)
//   i_d  : asynchronous input
//   o_q  : synchronized output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rstn,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Metastability-filter chain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_loop_ctrl.sv
// -----------------------------------------------------------------------------
// pll_loop_ctrl
// Digital PLL loop controller: measures the phase difference between a
// reference and a feedback clock in clk cycles, runs a PI loop filter and
// drives an NCO whose MSB is the generated clock.
//
// Ports:
//   clk          : sampling/system clock
//   rstn         : asynchronous active-low reset
//   en           : loop enable (0 forces IDLE and freezes the NCO)
//   ref_clk      : asynchronous reference clock
//   fb_clk       : asynchronous feedback clock
//   phase_signal : asynchronous PFD XOR output (falling edge ends a measurement)
//   tune_init    : nominal tuning word
//   gen_clk      : NCO clock output
//   tune_word    : current tuning word
//   phase_err    : last measured signed phase error (positive = ref leads)
//   err_valid    : one-cycle pulse when phase_err is refreshed
//   locked       : lock indicator
//
// Build option: define PLL_LOCK_DET_EN to include the lock detector; without
// it, locked is tied to 0 and no lock counter exists.
// -----------------------------------------------------------------------------
module pll_loop_ctrl
  import pll_pkg::*;
#(
  parameter int ERR_W    = ERR_W_DEF,
  parameter int TUNE_W   = TUNE_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int KP_SHIFT = KP_SHIFT_DEF,
  parameter int KI_SHIFT = KI_SHIFT_DEF,
  parameter int LOCK_TOL = LOCK_TOL_DEF,
  parameter int LOCK_CNT = LOCK_CNT_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    ref_clk,
  input  logic                    fb_clk,
  input  logic                    phase_signal,
  input  logic [TUNE_W-1:0]       tune_init,
  output logic                    gen_clk,
  output logic [TUNE_W-1:0]       tune_word,
  output logic signed [ERR_W-1:0] phase_err,
  output logic                    err_valid,
  output logic                    locked
);

  // Count holds only the magnitude; the sign is tracked separately.
  localparam int CNT_W = ERR_W - 1;
  localparam int INT_W = 2 * ERR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Elaboration-time guard against configurations the datapath cannot hold.
  if (LOCK_CNT < 1 || LOCK_TOL < 0 || TUNE_W > ACC_W || ERR_W < 2 ||
      KP_SHIFT < 0 || KI_SHIFT < 0) begin : g_bad_cfg
    $error("pll_loop_ctrl: unsupported parameter combination");
  end

  // ---------------------------------------------------------------------------
  // Input synchronization and edge detection
  // ---------------------------------------------------------------------------
  logic w_ref_s;
  logic w_fb_s;
  logic w_ph_s;
  logic r_ref_d;
  logic r_fb_d;
  logic r_ph_d;
  logic w_ref_rise;
  logic w_fb_rise;
  logic w_ph_fall;

  sync_2ff u_sync_ref (.clk(clk), .rstn(rstn), .i_d(ref_clk),      .o_q(w_ref_s));
  sync_2ff u_sync_fb  (.clk(clk), .rstn(rstn), .i_d(fb_clk),       .o_q(w_fb_s));
  sync_2ff u_sync_ph  (.clk(clk), .rstn(rstn), .i_d(phase_signal), .o_q(w_ph_s));

  // Previous synchronized levels for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ref_d <= 1'b0;
      r_fb_d  <= 1'b0;
      r_ph_d  <= 1'b0;
    end else begin
      r_ref_d <= w_ref_s;
      r_fb_d  <= w_fb_s;
      r_ph_d  <= w_ph_s;
    end
  end

  assign w_ref_rise = w_ref_s & ~r_ref_d;
  assign w_fb_rise  = w_fb_s  & ~r_fb_d;
  assign w_ph_fall  = ~w_ph_s & r_ph_d;

  // ---------------------------------------------------------------------------
  // Loop state
  // ---------------------------------------------------------------------------
  pll_state_e              r_state;
  pll_state_e              w_state_nxt;
  logic                    r_sign;       // 1 = feedback led (negative error)
  logic                    w_sign_nxt;
  logic [CNT_W-1:0]        r_count;
  logic [CNT_W-1:0]        w_count_nxt;
  logic [CNT_W-1:0]        w_count_inc;
  logic signed [INT_W-1:0] r_integ;
  logic signed [INT_W-1:0] w_integ_nxt;
  logic [TUNE_W-1:0]       r_tune;
  logic [TUNE_W-1:0]       w_tune_nxt;
  logic signed [ERR_W-1:0] r_err;
  logic signed [ERR_W-1:0] w_err_nxt;
  logic                    r_err_valid;
  logic                    w_err_valid_nxt;
  logic                    w_opp_edge;

  // Loop-filter datapath, evaluated from the finished measurement.
  logic signed [ERR_W-1:0] w_err_upd;
  logic signed [63:0]      w_err_ext;
  logic signed [63:0]      w_integ_sum;
  logic signed [63:0]      w_integ_sat;
  logic signed [63:0]      w_tune_sum;
  logic [TUNE_W-1:0]       w_tune_upd;

  assign w_count_inc = r_count + CNT_ONE;
  // The edge that closes a measurement is the one from the lagging clock.
  assign w_opp_edge  = r_sign ? w_ref_rise : w_fb_rise;

  // PI filter: integrator saturates at 2*ERR_W bits, tuning word clamps.
  always_comb begin
    w_err_upd   = r_sign ? -$signed({1'b0, r_count}) : $signed({1'b0, r_count});
    w_err_ext   = {{(64-ERR_W){w_err_upd[ERR_W-1]}}, w_err_upd};
    w_integ_sum = {{(64-INT_W){r_integ[INT_W-1]}}, r_integ} + w_err_ext;
    w_integ_sat = sat_signed(w_integ_sum, INT_W);
    w_tune_sum  = $signed({{(64-TUNE_W){1'b0}}, tune_init}) +
                  (w_err_ext >>> KP_SHIFT) + (w_integ_sat >>> KI_SHIFT);
    w_tune_upd  = TUNE_W'(clamp_unsigned(w_tune_sum, TUNE_W));
  end

  // Next-state and next-register logic of the measurement FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_sign_nxt      = r_sign;
    w_count_nxt     = r_count;
    w_integ_nxt     = r_integ;
    w_tune_nxt      = r_tune;
    w_err_nxt       = r_err;
    w_err_valid_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_integ_nxt = {INT_W{1'b0}};
        w_tune_nxt  = tune_init;
        w_count_nxt = {CNT_W{1'b0}};
        if (en) begin
          w_state_nxt = ST_WAIT_EDGE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_EDGE: begin
        if (!en) begin
          w_state_nxt = ST_IDLE;
        end else if (w_ref_rise && w_fb_rise) begin
          // Coincident edges: zero error, skip measuring.
          w_sign_nxt  = 1'b0;
          w_count_nxt = {CNT_W{1'b0}};
          w_state_nxt = ST_UPDATE;
        end else if (w_ref_rise) begin
          w_sign_nxt  = 1'b0;
          w_count_nxt = {CNT_W{1'b0}};
          w_state_nxt = ST_MEASURE;
        end else if (w_fb_rise) begin
          w_sign_nxt  = 1'b1;
          w_count_nxt = {CNT_W{1'b0}};
          w_state_nxt = ST_MEASURE;
        end else begin
          w_state_nxt = ST_WAIT_EDGE;
        end
      end
      ST_MEASURE: begin
        if (!en) begin
          w_count_nxt = {CNT_W{1'b0}};
          w_state_nxt = ST_IDLE;
        end else begin
          // The closing cycle is itself counted.
          w_count_nxt = w_count_inc;
          if (w_opp_edge || w_ph_fall || (w_count_inc == CNT_MAX)) begin
            w_state_nxt = ST_UPDATE;
          end else begin
            w_state_nxt = ST_MEASURE;
          end
        end
      end
      ST_UPDATE: begin
        if (!en) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_err_nxt       = w_err_upd;
          w_err_valid_nxt = 1'b1;
          w_integ_nxt     = w_integ_sat[INT_W-1:0];
          w_tune_nxt      = w_tune_upd;
          w_state_nxt     = ST_WAIT_EDGE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM and loop-filter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_sign      <= 1'b0;
      r_count     <= {CNT_W{1'b0}};
      r_integ     <= {INT_W{1'b0}};
      r_tune      <= {TUNE_W{1'b0}};
      r_err       <= {ERR_W{1'b0}};
      r_err_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sign      <= w_sign_nxt;
      r_count     <= w_count_nxt;
      r_integ     <= w_integ_nxt;
      r_tune      <= w_tune_nxt;
      r_err       <= w_err_nxt;
      r_err_valid <= w_err_valid_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // NCO
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] r_acc;
  logic             r_gen_clk;

  // Phase accumulator; gen_clk is the registered accumulator MSB.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc     <= {ACC_W{1'b0}};
      r_gen_clk <= 1'b0;
    end else if (en) begin
      r_acc     <= r_acc + ACC_W'(r_tune);
      r_gen_clk <= r_acc[ACC_W-1];
    end else begin
      r_acc     <= r_acc;
      r_gen_clk <= r_gen_clk;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock detector
  // ---------------------------------------------------------------------------
`ifdef PLL_LOCK_DET_EN
  localparam int LCNT_W = $clog2(LOCK_CNT + 1);
  localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(LOCK_CNT);
  localparam logic [LCNT_W-1:0] LCNT_ONE = {{(LCNT_W-1){1'b0}}, 1'b1};
  localparam logic signed [63:0] TOL_P = 64'(LOCK_TOL);

  logic [LCNT_W-1:0] r_lock_cnt;
  logic [LCNT_W-1:0] w_lock_cnt_nxt;
  logic              r_locked;
  logic              w_in_band;

  assign w_in_band = (w_err_ext <= TOL_P) && (w_err_ext >= -TOL_P);

  // Consecutive in-band update counter, saturating at LOCK_CNT.
  always_comb begin
    w_lock_cnt_nxt = r_lock_cnt;
    if (r_state == ST_IDLE) begin
      w_lock_cnt_nxt = {LCNT_W{1'b0}};
    end else if ((r_state == ST_UPDATE) && en) begin
      if (!w_in_band) begin
        w_lock_cnt_nxt = {LCNT_W{1'b0}};
      end else if (r_lock_cnt < LCNT_MAX) begin
        w_lock_cnt_nxt = r_lock_cnt + LCNT_ONE;
      end else begin
        w_lock_cnt_nxt = r_lock_cnt;
      end
    end else begin
      w_lock_cnt_nxt = r_lock_cnt;
    end
  end

  // Lock counter and lock flag registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lock_cnt <= {LCNT_W{1'b0}};
      r_locked   <= 1'b0;
    end else begin
      r_lock_cnt <= w_lock_cnt_nxt;
      r_locked   <= (w_lock_cnt_nxt == LCNT_MAX);
    end
  end

  assign locked = r_locked;
`else
  assign locked = 1'b0;
`endif

  assign gen_clk   = r_gen_clk;
  assign tune_word = r_tune;
  assign phase_err = r_err;
  assign err_valid = r_err_valid;

endmodule

// File: tb/tb_pll_loop_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pll_loop_ctrl
// Scoreboard bench: every measurement pushes the expected (error, tuning word,
// lock flag) computed by a plain-arithmetic loop model; a monitor pops and
// compares whenever err_valid is seen. Directed checks cover reset, NCO
// activity and the enable-drop freeze.
// -----------------------------------------------------------------------------
module tb_pll_loop_ctrl;

  localparam int ERR_W    = 12;
  localparam int TUNE_W   = 16;
  localparam int ACC_W    = 24;
  localparam int KP_SHIFT = 1;
  localparam int KI_SHIFT = 4;
  localparam int LOCK_TOL = 2;
  localparam int LOCK_CNT = 8;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic                    en;
  logic                    ref_clk;
  logic                    fb_clk;
  logic                    phase_signal;
  logic [TUNE_W-1:0]       tune_init;
  logic                    gen_clk;
  logic [TUNE_W-1:0]       tune_word;
  logic signed [ERR_W-1:0] phase_err;
  logic                    err_valid;
  logic                    locked;

  always #5 clk = ~clk;

  pll_loop_ctrl #(
    .ERR_W(ERR_W), .TUNE_W(TUNE_W), .ACC_W(ACC_W), .KP_SHIFT(KP_SHIFT),
    .KI_SHIFT(KI_SHIFT), .LOCK_TOL(LOCK_TOL), .LOCK_CNT(LOCK_CNT)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .ref_clk(ref_clk), .fb_clk(fb_clk),
    .phase_signal(phase_signal), .tune_init(tune_init), .gen_clk(gen_clk),
    .tune_word(tune_word), .phase_err(phase_err), .err_valid(err_valid),
    .locked(locked)
  );

  typedef struct {
    longint err;
    longint tune;
    bit     lck;
  } exp_t;

  exp_t   exp_q[$];
  int     n_vec = 0;
  int     n_bad = 0;
  longint m_integ = 0;
  int     m_lock  = 0;

  // Mathematical floor division (arithmetic right shift semantics).
  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  // Reference loop model: one PI update for a measured error.
  task automatic expect_update(input longint err);
    exp_t   e;
    longint lim;
    longint t;
    lim = longint'(1) << (2 * ERR_W - 1);
    m_integ = m_integ + err;
    if (m_integ > lim - 1) m_integ = lim - 1;
    if (m_integ < -lim) m_integ = -lim;
    t = longint'(tune_init) + floor_div(err, longint'(1) << KP_SHIFT)
        + floor_div(m_integ, longint'(1) << KI_SHIFT);
    if (t < 0) t = 0;
    if (t > (longint'(1) << TUNE_W) - 1) t = (longint'(1) << TUNE_W) - 1;
    if (err <= LOCK_TOL && err >= -LOCK_TOL) begin
      if (m_lock < LOCK_CNT) m_lock = m_lock + 1;
    end else begin
      m_lock = 0;
    end
    e.err  = err;
    e.tune = t;
`ifdef PLL_LOCK_DET_EN
    e.lck  = (m_lock == LOCK_CNT);
`else
    e.lck  = 1'b0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rstn === 1'b1 && err_valid === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_err_valid: phase_err=%0d tune_word=0x%h", phase_err, tune_word);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (longint'(phase_err) != e.err || longint'(tune_word) != e.tune || locked !== e.lck) begin
          n_bad++;
          $display("FAIL update: got err=%0d tune=0x%h locked=%0b, want err=%0d tune=0x%h locked=%0b",
                   phase_err, tune_word, locked, e.err, e.tune, e.lck);
        end
      end
    end
  end

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout: %0d expected updates not seen", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic settle();
    @(negedge clk);
    ref_clk = 1'b0;
    fb_clk = 1'b0;
    phase_signal = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // d > 0: ref leads by d cycles; d < 0: fb leads; by_phase ends via phase_signal.
  task automatic run_meas(input int d, input bit by_phase);
    int n;
    n = (d < 0) ? -d : d;
    expect_update(longint'(d));
    if (d >= 0) ref_clk = 1'b1;
    if (d <= 0) fb_clk = 1'b1;
    if (n > 0) begin
      repeat (n) @(negedge clk);
      if (by_phase) phase_signal = 1'b0;
      else if (d > 0) fb_clk = 1'b1;
      else ref_clk = 1'b1;
    end
    wait_drain(60);
    settle();
  endtask

  task automatic fresh_idle(input logic [TUNE_W-1:0] ti);
    en = 1'b0;
    repeat (4) @(negedge clk);
    tune_init = ti;
    m_integ = 0;
    m_lock = 0;
    en = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int toggles;
    logic g0;
    rstn = 1'b0; en = 1'b0; ref_clk = 1'b0; fb_clk = 1'b0;
    phase_signal = 1'b1; tune_init = 16'h1000;
    repeat (3) @(negedge clk);
    check("rst_tune_word", tune_word, 0);
    check("rst_phase_err", phase_err, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_gen_clk", gen_clk, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("tune_after_reset", tune_word, 16'h1000);

    // NCO: step 0x1000 on a 24-bit accumulator flips the MSB every 2048 cycles.
    en = 1'b1;
    g0 = gen_clk;
    toggles = 0;
    repeat (8192) begin
      @(negedge clk);
      if (gen_clk !== g0) begin toggles++; g0 = gen_clk; end
    end
    check("nco_toggles_min", (toggles >= 3) ? 1 : 0, 1);
    check("nco_toggles_max", (toggles <= 5) ? 1 : 0, 1);

    fresh_idle(16'h1000);
    run_meas(10, 1'b0);            // +10 -> 0x1005
    fresh_idle(16'h1000);
    run_meas(-6, 1'b0);            // -6 -> 0x0FFC
    fresh_idle(16'h1000);
    run_meas(0, 1'b0);             // coincident -> 0x1000

    // Saturation: ref only, phase_signal held high.
    fresh_idle(16'h1000);
    expect_update(2047);
    ref_clk = 1'b1;
    wait_drain(2200);
    settle();

    fresh_idle(16'hFFF0);
    run_meas(100, 1'b0);           // clamps to 0xFFFF
    fresh_idle(16'h1000);

    // Repeated ref edges during measurement are ignored.
    expect_update(12);
    ref_clk = 1'b1;
    repeat (4) @(negedge clk);
    ref_clk = 1'b0;
    repeat (3) @(negedge clk);
    ref_clk = 1'b1;
    repeat (5) @(negedge clk);
    fb_clk = 1'b1;
    wait_drain(60);
    settle();

    run_meas(7, 1'b1);             // ended by phase_signal falling
    run_meas(-9, 1'b1);

    // Lock sequence: eight in-band updates, then one out of band.
    fresh_idle(16'h1000);
    repeat (8) run_meas(1, 1'b0);
    run_meas(5, 1'b0);

    for (int k = 0; k < 24; k++) begin
      int d;
      bit bp;
      d = int'($urandom_range(80, 0)) - 40;
      bp = (d != 0) && ($urandom_range(1, 0) == 1);
      run_meas(d, bp);
    end

    // Enable drop mid-measurement: no update, tune_word restored, NCO frozen.
    ref_clk = 1'b1;
    repeat (6) @(negedge clk);
    en = 1'b0;
    m_integ = 0;
    m_lock = 0;
    repeat (2) @(negedge clk);
    g0 = gen_clk;
    toggles = 0;
    repeat (3000) begin
      @(negedge clk);
      if (gen_clk !== g0) toggles++;
    end
    check("en_off_gen_frozen", toggles, 0);
    check("en_off_tune_word", tune_word, 16'h1000);
    check("en_off_locked", locked, 0);
    ref_clk = 1'b0;
    repeat (6) @(negedge clk);
    en = 1'b1;
    repeat (4) @(negedge clk);
    run_meas(3, 1'b0);

    check("queue_empty_at_end", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
